alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Accepts one operation per start pulse, using the same 4-bit ALU control encoding plus new shift and multiply ops.
- Returns a registered result with a busy/done handshake, and maintains a status flag register (Z, N, V, C) written only on completed, flag-enabled operations.
- Sits in the EX stage of a multi-cycle datapath. The control FSM stalls on busy.

---
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, multi-cycle EX-stage ALU: one operation per accepted start, result and
// Z/N/V/C status returned with a busy/done handshake; MULLO runs as an iterative shift-add.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       gin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zout,
  output logic             illegal,
  output logic             statusZ,
  output logic             statusN,
  output logic             statusV,
  output logic             statusC
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam int         MSB     = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             fwe_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [SHW-1:0]   cnt_q;
  logic             accept;

  // Handshake: start is taken only on a cycle with busy=0; busy stays high from the
  // accepting edge until the FIN edge, and done pulses for exactly the following cycle.
  assign busy   = (state_q != S_IDLE);
  assign accept = (state_q == S_IDLE) && start;
  assign zout   = ~|result;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (gin == OP_MUL) ? S_MUL : S_FIN;
      S_MUL:  if (cnt_q == SHW'(WIDTH - 1)) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [WIDTH:0]   sum_x, dif_x;
  logic             v_add, v_sub;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  logic             ill_c, v_c, c_c;

  always_comb begin
    sum_x = {1'b0, a_q} + {1'b0, b_q};
    dif_x = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    v_add = (a_q[MSB] == b_q[MSB]) && (sum_x[MSB] != a_q[MSB]);
    v_sub = (a_q[MSB] != b_q[MSB]) && (dif_x[MSB] != a_q[MSB]);
    shamt = b_q[SHW-1:0];
    res_c = '0;
    ill_c = 1'b0;
    v_c   = 1'b0;
    c_c   = 1'b0;
    case (op_q)
      OP_ADD:  begin res_c = sum_x[WIDTH-1:0]; v_c = v_add; c_c = sum_x[WIDTH]; end
      OP_SUB:  begin res_c = dif_x[WIDTH-1:0]; v_c = v_sub; c_c = dif_x[WIDTH]; end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, dif_x[MSB] ^ v_sub};
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_NOR:  res_c = ~(a_q | b_q);
      OP_XOR:  res_c = a_q ^ b_q;
      OP_PASS: res_c = a_q;
      OP_SLL:  res_c = a_q << shamt;
      OP_SRL:  res_c = a_q >> shamt;
      OP_SRA:  res_c = $signed(a_q) >>> shamt;
      OP_MUL:  res_c = acc_q;
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fwe_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
      result   <= '0;
      illegal  <= 1'b0;
      statusZ  <= 1'b0;
      statusN  <= 1'b0;
      statusV  <= 1'b0;
      statusC  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q     <= gin;
        a_q      <= a;
        b_q      <= b;
        fwe_q    <= flag_we;
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        cnt_q    <= '0;
        illegal  <= 1'b0;
      end
      if (state_q == S_MUL) begin
        // One multiplier bit per cycle; latency does not depend on operand values.
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
      end
      if (state_q == S_FIN) begin
        result  <= res_c;
        illegal <= ill_c;
        done    <= 1'b1;
        if (fwe_q && !ill_c) begin
          statusZ <= ~|res_c;
          statusN <= res_c[MSB];
          statusV <= v_c;
          statusC <= c_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): opcode vector table, MULLO latency/stall, reset abort
// and illegal-opcode sequences, with a result/illegal scoreboard fed at issue time.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flag_we;
  logic [3:0]   gin;
  logic [W-1:0] a, b;
  logic         busy, done, zout, illegal;
  logic [W-1:0] result;
  logic         statusZ, statusN, statusV, statusC;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ill_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .gin(gin), .a(a), .b(b), .flag_we(flag_we),
    .busy(busy), .done(done), .result(result), .zout(zout), .illegal(illegal),
    .statusZ(statusZ), .statusN(statusN), .statusV(statusV), .statusC(statusC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding issued operation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", result, exp_q.pop_front());
        chk("illegal", {31'd0, illegal}, {31'd0, exp_ill_q.pop_front()});
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_result"}, result, 32'd0);
    chk({nm, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({nm, "_flags"}, {28'd0, statusZ, statusN, statusV, statusC}, 32'd0);
    chk({nm, "_zout"}, {31'd0, zout}, 32'd1);
  endtask

  // Issues one op, optionally injects an ADD start while busy at edge t+inj_at.
  task automatic do_op(input string nm, input logic [3:0] g, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic fwe, input logic [W-1:0] er,
                       input logic eill, input logic [3:0] ef, input int inj_at);
    int lat;
    int elat;
    elat = (g == 4'b0011) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; gin = g; a = va; b = vb; flag_we = fwe;
    exp_q.push_back(er);
    exp_ill_q.push_back(eill);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; gin = 4'($urandom_range(0, 15)); flag_we = 1'($urandom_range(0, 1));
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 200) begin
      if (inj_at != 0 && lat == inj_at - 1) begin
        start = 1'b1; gin = 4'b0010; a = 32'd1; b = 32'd1; flag_we = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
      void'(exp_q.pop_back());
      void'(exp_ill_q.pop_back());
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_flags"}, {28'd0, statusZ, statusN, statusV, statusC}, {28'd0, ef});
    chk({nm, "_zout"}, {31'd0, zout}, {31'd0, (er == 0)});
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct packed {
    logic [3:0]   gin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fwe;
    logic [W-1:0] res;
    logic         ill;
    logic [3:0]   flags;  // Z N V C after the op
  } vec_t;

  vec_t vecs[20];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 4'b0110};
    vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 4'b1001};
    vecs[2]  = '{4'b0000, 32'h000000F0, 32'h0000000F, 1'b0, 32'h00000000, 1'b0, 4'b1001};
    vecs[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b0, 4'b0000};
    vecs[4]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 4'b0000};
    vecs[5]  = '{4'b1011, 32'h80000000, 32'h00000004, 1'b1, 32'hF8000000, 1'b0, 4'b0100};
    vecs[6]  = '{4'b0101, 32'h80000000, 32'h00000004, 1'b1, 32'h08000000, 1'b0, 4'b0000};
    vecs[7]  = '{4'b0100, 32'h00000001, 32'h00000021, 1'b1, 32'h00000002, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0001, 32'h0F0F0000, 32'h000000FF, 1'b1, 32'h0F0F00FF, 1'b0, 4'b0000};
    vecs[9]  = '{4'b1010, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b0100};
    vecs[10] = '{4'b1001, 32'hFFFF0000, 32'hFF00FF00, 1'b1, 32'h00FFFF00, 1'b0, 4'b0000};
    vecs[11] = '{4'b1000, 32'h00000000, 32'h0000007B, 1'b1, 32'h00000000, 1'b0, 4'b1000};
    vecs[12] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 4'b1001};
    vecs[13] = '{4'b0110, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b0100};
    vecs[14] = '{4'b0110, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 4'b0011};
    vecs[15] = '{4'b0010, 32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 4'b0011};
    vecs[16] = '{4'b0110, 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b0, 4'b1001};
    vecs[17] = '{4'b1111, 32'h12345678, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 4'b1001};
    vecs[18] = '{4'b1101, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4'b1001};
    vecs[19] = '{4'b0010, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 4'b1001};

    reset = 1'b1; start = 1'b0; flag_we = 1'b0; gin = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].gin, vecs[i].a, vecs[i].b, vecs[i].fwe,
            vecs[i].res, vecs[i].ill, vecs[i].flags, 0);
    end

    // MULLO with an ADD start injected mid-operation; the ADD must be ignored.
    do_op("mul_stall", 4'b0011, 32'h0000FFFF, 32'h00010001, 1'b1, 32'hFFFFFFFF, 1'b0, 4'b0100, 5);
    repeat (5) @(negedge clk);
    do_op("mul_zero", 4'b0011, 32'h00000000, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 4'b1000, 0);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ra, rb, rp;
      ra = $urandom; rb = $urandom; rp = ra * rb;
      do_op($sformatf("mul_rand%0d", i), 4'b0011, ra, rb, 1'b0, rp, 1'b0, 4'b1000, 0);
    end

    // Reset at edge t+10 of a MULLO: aborted, no done pulse may follow.
    @(negedge clk);
    start = 1'b1; gin = 4'b0011; a = 32'h00001234; b = 32'h00005678; flag_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("abort");
    repeat (40) @(negedge clk);
    do_op("after_abort", 4'b0010, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0, 4'b0000, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
